// File: rtl/grid_row_reader_if.sv
// Handshake bundle between a grid producer/row sink (master) and the row reader (slave).
`timescale 1ns/1ps
interface grid_row_reader_if #(
  parameter int unsigned DROP_W = 8
);
  logic [63:0]       grid_in;
  logic              grid_valid;
  logic [7:0]        row_out;
  logic [2:0]        row_idx;
  logic              row_valid;
  logic              row_ready;
  logic              frame_start;
  logic              frame_end;
  logic              busy;
  logic [DROP_W-1:0] drop_count;

  modport master (
    output grid_in, grid_valid, row_ready,
    input  row_out, row_idx, row_valid, frame_start, frame_end, busy, drop_count
  );

  modport slave (
    input  grid_in, grid_valid, row_ready,
    output row_out, row_idx, row_valid, frame_start, frame_end, busy, drop_count
  );
endinterface

// File: rtl/grid_row_reader.sv
// Snapshots 64-bit Life generations and streams them row by row over valid/ready,
// with a one-deep pending buffer and a saturating drop counter.
`timescale 1ns/1ps
module grid_row_reader #(
  parameter int unsigned DROP_W = 8
) (
  input logic             clk,
  input logic             reset,
  grid_row_reader_if.slave bus
);
  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state;
  logic [63:0]       active;
  logic [63:0]       pending;
  logic              pend_full;
  logic [2:0]        idx;
  logic [DROP_W-1:0] drop_cnt;

  logic xfer;
  logic frame_done;

  assign xfer       = (state == StSend) && bus.row_ready;
  assign frame_done = xfer && (idx == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      idx       <= '0;
      drop_cnt  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.grid_valid) begin
            active <= bus.grid_in;
            idx    <= '0;
            state  <= StSend;
          end
        end
        StSend: begin
          if (frame_done) begin
            // A generation arriving on the frame-done edge is never dropped.
            if (pend_full) begin
              active <= pending;
              idx    <= '0;
              if (bus.grid_valid) pending <= bus.grid_in;
              else                pend_full <= 1'b0;
            end else if (bus.grid_valid) begin
              active <= bus.grid_in;
              idx    <= '0;
            end else begin
              idx   <= '0;
              state <= StIdle;
            end
          end else begin
            if (xfer) idx <= idx + 3'd1;
            if (bus.grid_valid) begin
              if (!pend_full) begin
                pending   <= bus.grid_in;
                pend_full <= 1'b1;
              end else if (drop_cnt != {DROP_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.row_out     = active[8*idx +: 8];
  assign bus.row_idx     = idx;
  assign bus.row_valid   = (state == StSend);
  assign bus.frame_start = bus.row_valid && (idx == 3'd0);
  assign bus.frame_end   = bus.row_valid && (idx == 3'd7);
  assign bus.busy        = (state == StSend) || pend_full;
  assign bus.drop_count  = drop_cnt;
endmodule
